// File: rtl/ram_loader.sv
// ram_loader: byte-stream RAM loader; cmd (01 write / 02 read), 4 addr bytes, 2 len bytes (LSB first), payload.
// Latency: each accepted write byte reaches the RAM port on the next cycle; reads take 3 cycles plus the tx handshake per byte.
// Backpressure: rx_ready_o is low in the read, status and reset states; tx_data_o is held while tx_valid_o=1 and tx_ready_i=0.
// Option: define RAM_LOADER_CHECKSUM_EN to add an XOR checksum byte and a 00/FF status reply to write frames.
module ram_loader #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [7:0]      rx_data_i,
  input  logic            rx_valid_i,
  output logic            rx_ready_o,
  output logic [7:0]      tx_data_o,
  output logic            tx_valid_o,
  input  logic            tx_ready_i,
  output logic            ram_rw_sel_o,
  output logic [XLEN-1:0] ram_rw_addr_o,
  output logic [7:0]      ram_wr_data_o,
  output logic [3:0]      ram_wr_byte_en_o,
  input  logic [7:0]      ram_rd_data_i,
  output logic            busy_o,
  output logic            err_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_LEN, S_WRITE, S_RD_REQ, S_RD_CAP, S_RD_SEND
`ifdef RAM_LOADER_CHECKSUM_EN
    , S_CHECK, S_STATUS
`endif
  } state_t;

  state_t          state_q, state_d;
  logic            is_read_q;
  logic [1:0]      idx_q;
  logic [XLEN-1:0] addr_q;
  logic [15:0]     cnt_q;
  logic [7:0]      tx_hold_q;
  logic            wr_pend_q;
  logic [7:0]      wr_data_q;
  logic            err_q;
`ifdef RAM_LOADER_CHECKSUM_EN
  logic [7:0]      csum_q;
`endif

  logic rx_fire, tx_fire, cmd_ok;
  assign rx_fire = rx_valid_i && rx_ready_o;
  assign tx_fire = tx_valid_o && tx_ready_i;
  assign cmd_ok  = (rx_data_i == 8'h01) || (rx_data_i == 8'h02);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; write frames end in CHECK when the checksum option is built in
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (rx_fire && cmd_ok) state_d = S_ADDR;
      S_ADDR:  if (rx_fire && idx_q == 2'd3) state_d = S_LEN;
      S_LEN: begin
        if (rx_fire && idx_q == 2'd1) begin
          if ({rx_data_i, cnt_q[7:0]} == 16'd0) begin
`ifdef RAM_LOADER_CHECKSUM_EN
            state_d = is_read_q ? S_IDLE : S_CHECK;
`else
            state_d = S_IDLE;
`endif
          end else begin
            state_d = is_read_q ? S_RD_REQ : S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (rx_fire && cnt_q == 16'd1) begin
`ifdef RAM_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_IDLE;
`endif
        end
      end
      S_RD_REQ:  state_d = S_RD_CAP;
      S_RD_CAP:  state_d = S_RD_SEND;
      S_RD_SEND: if (tx_fire) state_d = (cnt_q == 16'd1) ? S_IDLE : S_RD_REQ;
`ifdef RAM_LOADER_CHECKSUM_EN
      S_CHECK:   if (rx_fire) state_d = S_STATUS;
      S_STATUS:  if (tx_fire) state_d = S_IDLE;
`endif
      default:   state_d = S_IDLE;
    endcase
  end

  // Output decode; rx_ready_o is held low while reset is asserted
  always_comb begin
    rx_ready_o       = 1'b0;
    tx_valid_o       = 1'b0;
    ram_rw_sel_o     = wr_pend_q;
    ram_wr_byte_en_o = 4'b0000;
    case (state_q)
      S_IDLE, S_ADDR, S_LEN: rx_ready_o = 1'b1;
      S_WRITE: begin
        rx_ready_o   = 1'b1;
        ram_rw_sel_o = 1'b1;
      end
      S_RD_REQ, S_RD_CAP: ram_rw_sel_o = 1'b1;
      S_RD_SEND: begin
        ram_rw_sel_o = 1'b1;
        tx_valid_o   = 1'b1;
      end
`ifdef RAM_LOADER_CHECKSUM_EN
      S_CHECK:  rx_ready_o = 1'b1;
      S_STATUS: tx_valid_o = 1'b1;
`endif
      default: ;
    endcase
    if (rst_i) rx_ready_o = 1'b0;
    // Region 0x00 is byte-laned RAM, region 0x10 is a single-lane device, anything else is dropped
    if (wr_pend_q) begin
      if (addr_q[31:24] == 8'h00)      ram_wr_byte_en_o = 4'b0001 << addr_q[1:0];
      else if (addr_q[31:24] == 8'h10) ram_wr_byte_en_o = 4'b0001;
      else                             ram_wr_byte_en_o = 4'b0000;
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign ram_rw_addr_o = addr_q;
  assign ram_wr_data_o = wr_data_q;
  assign tx_data_o     = tx_hold_q;
  assign err_o         = err_q;

  // Datapath: header capture, write staging, address/count stepping, tx holding register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      is_read_q <= 1'b0;
      idx_q     <= 2'd0;
      addr_q    <= '0;
      cnt_q     <= 16'd0;
      tx_hold_q <= 8'h00;
      wr_pend_q <= 1'b0;
      wr_data_q <= 8'h00;
      err_q     <= 1'b0;
`ifdef RAM_LOADER_CHECKSUM_EN
      csum_q    <= 8'h00;
`endif
    end else begin
      err_q     <= 1'b0;
      wr_pend_q <= 1'b0;
      // The address advances in the write cycle itself, so it is the byte's own address on the port
      if (wr_pend_q) addr_q <= addr_q + XLEN'(1);
      case (state_q)
        S_IDLE: begin
          if (rx_fire) begin
            if (cmd_ok) begin
              is_read_q <= (rx_data_i == 8'h02);
              idx_q     <= 2'd0;
              cnt_q     <= 16'd0;
              addr_q    <= '0;
`ifdef RAM_LOADER_CHECKSUM_EN
              csum_q    <= 8'h00;
`endif
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_ADDR: begin
          if (rx_fire) begin
            case (idx_q)
              2'd0:    addr_q[7:0]   <= rx_data_i;
              2'd1:    addr_q[15:8]  <= rx_data_i;
              2'd2:    addr_q[23:16] <= rx_data_i;
              default: addr_q[31:24] <= rx_data_i;
            endcase
            idx_q <= idx_q + 2'd1;
          end
        end
        S_LEN: begin
          if (rx_fire) begin
            if (idx_q == 2'd0) cnt_q[7:0]  <= rx_data_i;
            else               cnt_q[15:8] <= rx_data_i;
            idx_q <= idx_q + 2'd1;
          end
        end
        S_WRITE: begin
          if (rx_fire) begin
            wr_pend_q <= 1'b1;
            wr_data_q <= rx_data_i;
            cnt_q     <= cnt_q - 16'd1;
`ifdef RAM_LOADER_CHECKSUM_EN
            csum_q    <= csum_q ^ rx_data_i;
`endif
          end
        end
        S_RD_CAP: tx_hold_q <= ram_rd_data_i;
        S_RD_SEND: begin
          if (tx_fire) begin
            addr_q <= addr_q + XLEN'(1);
            cnt_q  <= cnt_q - 16'd1;
          end
        end
`ifdef RAM_LOADER_CHECKSUM_EN
        S_CHECK: if (rx_fire) tx_hold_q <= (rx_data_i == csum_q) ? 8'h00 : 8'hFF;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 SHALL have parameter XLEN, default 32, RAM address width.
REQ-002 SHALL have ports (name direction width meaning):
- clk_i in 1: clock.
- rst_i in 1: reset.
- rx_data_i in 8: command byte stream.
- rx_valid_i in 1: rx byte valid.
- rx_ready_o out 1: rx byte accepted.
- tx_data_o out 8: response byte stream.
- tx_valid_o out 1: tx byte valid.
- tx_ready_i in 1: tx byte taken.
- ram_rw_sel_o out 1: RAM load port owns RAM.
- ram_rw_addr_o out XLEN: RAM byte address.
- ram_wr_data_o out 8: RAM write byte.
- ram_wr_byte_en_o out 4: RAM write lane enables.
- ram_rd_data_i in 8: RAM read byte, valid 1 cycle after address.
- busy_o out 1: transfer in progress.
- err_o out 1: one-cycle pulse on unknown command.
REQ-003 SHALL use one clock, clk_i; reset rst_i SHALL be asynchronous and active-high.

Function
REQ-004 SHALL accept rx bytes only when rx_valid_i && rx_ready_o; tx bytes transfer only when tx_valid_o && tx_ready_i. tx_data_o SHALL remain stable while tx_valid_o=1 and tx_ready_i=0.
REQ-005 Frame format SHALL be: cmd (0x01 write, 0x02 read), 4 address bytes LSB first, 2 length bytes LSB first, then payload (write only).
REQ-006 FSM states SHALL be IDLE, ADDR, LEN, WRITE, RD_REQ, RD_CAP, RD_SEND, plus CHECK and STATUS when REQ-016 is enabled.
REQ-007 IDLE: rx_ready_o=1. 0x01/0x02 -> ADDR. Any other byte is dropped, err_o pulses for 1 cycle, FSM stays in IDLE.
REQ-008 ADDR -> LEN after 4 bytes. LEN -> WRITE (cmd 0x01) or RD_REQ (cmd 0x02) after 2 bytes. Length 0 SHALL return to IDLE (or go to CHECK when enabled) with no RAM access.
REQ-009 WRITE: rx_ready_o=1. A byte accepted in cycle N SHALL drive a write to the RAM port in cycle N+1 for exactly one cycle, with ram_wr_data_o = byte and ram_rw_addr_o = current address. Address then +1 and remaining count -1; count reaching 0 -> IDLE.
REQ-010 Write lane rule: address[31:24]=0x00 -> ram_wr_byte_en_o = 4'b0001 << addr[1:0]; address[31:24]=0x10 -> 4'b0001; any other region -> 4'b0000 (byte consumed, no write).
REQ-011 ram_wr_byte_en_o SHALL be 0 in every cycle except write cycles.
REQ-012 Read path: RD_REQ drives the address, RD_CAP registers ram_rd_data_i into the tx holding register, RD_SEND asserts tx_valid_o until accepted, then address +1 and count -1. Count >0 -> RD_REQ; count =0 -> IDLE. ram_rw_addr_o SHALL be stable across RD_REQ and RD_CAP.
REQ-013 ram_rw_sel_o SHALL be 1 in WRITE, RD_REQ, RD_CAP, RD_SEND, and the trailing write cycle; 0 otherwise. busy_o SHALL be 1 whenever state != IDLE.
REQ-014 Address arithmetic SHALL be XLEN-bit and wrap from all-ones to 0; the count is 16 bits.

Reset
REQ-015 While rst_i=1: state SHALL be IDLE and all outputs 0, except rx_ready_o=1 after release. Asserting reset mid-frame SHALL abort the frame with no further RAM write.

Configuration
REQ-016 Macro RAM_LOADER_CHECKSUM_EN:
- Defined: after a write payload, CHECK accepts one byte. The FSM compares it to the XOR of all payload bytes (0x00 for length 0). STATUS then sends 0x00 on match or 0xFF on mismatch, then returns to IDLE. RAM writes are not undone.
- Undefined: no CHECK/STATUS states; write frames end after the payload.

Verification
REQ-017 Stream 01 00 00 00 00 04 00 AA BB CC DD -> four one-cycle writes at 0x0,0x1,0x2,0x3 with byte_en 1,2,4,8 and data AA,BB,CC,DD.
REQ-018 Write 1 byte 0x5A at 0x10000003 -> a single write with ram_wr_byte_en_o=4'b0001 and address 0x10000003.
REQ-019 Read frame 02 01 00 00 00 03 00 after preloading 11 22 33 at 0x1 -> tx emits 11 22 33 in order. With tx_ready_i held low for 5 cycles, tx_data_o holds 11 and there is no extra RAM access.
REQ-020 Byte 0x7F in IDLE -> err_o high for exactly 1 cycle, busy_o stays 0, and the next frame is processed normally.
REQ-021 rst_i pulsed after the 2nd of 4 payload bytes -> no further writes, busy_o=0, and the following frame succeeds.
REQ-022 With RAM_LOADER_CHECKSUM_EN defined: payload 01 02 plus checksum 03 -> tx 0x00; checksum 04 -> tx 0xFF.
